issue_ctrl_n: RTL and testbench

- Parametrised in-order N-wide issue controller. It generalises the fixed dual-issue stage to ISSUE_WIDTH lanes and STAGES tracked post-issue positions.
- It embeds its own per-register scoreboard, which tracks the pipeline position of each in-flight write as a shift register.
- It resolves operands from the regfile, from per-stage bypass, or from immediates, and registers the selected group into the FU launch register.
- It sits between the issue queue and the execute lanes.

---
 rtl/issue_ctrl_n.sv | 195 +++++++++++++++++++
 tb/tb_issue_ctrl_n.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/issue_ctrl_n.sv
// In-order N-wide issue controller with an embedded shift-register scoreboard,
// operand resolution (regfile / per-stage bypass / immediate) and FU launch register.
module issue_ctrl_n #(
    parameter int unsigned ISSUE_WIDTH = 2,
    parameter int unsigned STAGES      = 3,
    parameter int unsigned NREG        = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                flush,
    input  logic                                stall,
    input  logic [$clog2(ISSUE_WIDTH+1)-1:0]    iq_size,
    input  logic [2*ISSUE_WIDTH-1:0]            src_need,
    input  logic [2*ISSUE_WIDTH*5-1:0]          src_addr,
    input  logic [2*ISSUE_WIDTH*32-1:0]         imm,
    input  logic [ISSUE_WIDTH-1:0]              dst_need,
    input  logic [ISSUE_WIDTH*5-1:0]            dst_addr,
    input  logic [ISSUE_WIDTH*STAGES-1:0]       accept_mask,
    input  logic [ISSUE_WIDTH-1:0]              is_branch,
    output logic [2*ISSUE_WIDTH*5-1:0]          rf_raddr,
    input  logic [2*ISSUE_WIDTH*32-1:0]         rf_rdata,
    input  logic [STAGES*ISSUE_WIDTH*32-1:0]    byp_data,
    output logic [$clog2(ISSUE_WIDTH+1)-1:0]    iq_pop,
    output logic [ISSUE_WIDTH-1:0]              fu_valid,
    output logic [ISSUE_WIDTH*32-1:0]           fu_op1,
    output logic [ISSUE_WIDTH*32-1:0]           fu_op2,
    output logic [ISSUE_WIDTH*6-1:0]            fu_dst
);

    localparam int unsigned PW = $clog2(ISSUE_WIDTH + 1);
    localparam int unsigned LW = (ISSUE_WIDTH > 1) ? $clog2(ISSUE_WIDTH) : 1;
    localparam int unsigned RW = (NREG > 1) ? $clog2(NREG) : 1;
    localparam int unsigned AW = 5;
    localparam int unsigned DW = 32;

    logic [STAGES-1:0] pos_q  [NREG];
    logic [STAGES-1:0] pos_d  [NREG];
    logic [STAGES-1:0] mask_q [NREG];
    logic [STAGES-1:0] mask_d [NREG];
    logic [LW-1:0]     lane_q [NREG];
    logic [LW-1:0]     lane_d [NREG];

    logic [ISSUE_WIDTH-1:0]    fu_valid_q, fu_valid_d;
    logic [ISSUE_WIDTH*DW-1:0] fu_op1_q, fu_op1_d;
    logic [ISSUE_WIDTH*DW-1:0] fu_op2_q, fu_op2_d;
    logic [ISSUE_WIDTH*6-1:0]  fu_dst_q, fu_dst_d;

    logic [DW-1:0]          opnd_c [ISSUE_WIDTH][2];
    logic [ISSUE_WIDTH-1:0] elig_c;
    int                     pop_len_c;

    assign rf_raddr = src_addr;
    assign fu_valid = fu_valid_q;
    assign fu_op1   = fu_op1_q;
    assign fu_op2   = fu_op2_q;
    assign fu_dst   = fu_dst_q;

    // Resolve each source operand and decide per-lane eligibility.
    always_comb begin
        int k;
        int ra;
        logic [RW-1:0] ri;
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            elig_c[i] = (i < int'(iq_size));
            for (int s = 0; s < 2; s++) begin
                k  = 2 * i + s;
                ra = int'(src_addr[k*AW +: AW]);
                ri = RW'(ra);
                opnd_c[i][s] = rf_rdata[k*DW +: DW];
                if (!src_need[k]) begin
                    opnd_c[i][s] = imm[k*DW +: DW];
                end else begin
                    if (ra != 0 && ra < int'(NREG) && pos_q[ri] != '0) begin
                        if ((pos_q[ri] & mask_q[ri]) != '0) begin
                            for (int st = 0; st < int'(STAGES); st++) begin
                                if (pos_q[ri][st]) begin
                                    opnd_c[i][s] = byp_data[(st*int'(ISSUE_WIDTH) + int'(lane_q[ri]))*DW +: DW];
                                end
                            end
                        end else begin
                            elig_c[i] = 1'b0;
                        end
                    end
                    // no forwarding between lanes of one group
                    for (int j = 0; j < i; j++) begin
                        if (dst_need[j] && dst_addr[j*AW +: AW] != '0 &&
                            dst_addr[j*AW +: AW] == src_addr[k*AW +: AW]) begin
                            elig_c[i] = 1'b0;
                        end
                    end
                end
            end
        end
    end

    // Longest eligible prefix, trimmed so a branch never leaves its delay slot behind.
    always_comb begin
        logic stop;
        pop_len_c = 0;
        stop      = 1'b0;
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
            if (!stop && elig_c[i]) begin
                pop_len_c = i + 1;
            end else begin
                stop = 1'b1;
            end
        end
        for (int j = int'(ISSUE_WIDTH) - 1; j >= 0; j--) begin
            if (pop_len_c == j + 1 && is_branch[j]) begin
                pop_len_c = j;
            end
        end
        if (stall || flush) begin
            pop_len_c = 0;
        end
        iq_pop = PW'(pop_len_c);
    end

    // Next scoreboard and launch register contents.
    always_comb begin
        logic [RW-1:0] wi;
        pos_d      = pos_q;
        mask_d     = mask_q;
        lane_d     = lane_q;
        fu_valid_d = fu_valid_q;
        fu_op1_d   = fu_op1_q;
        fu_op2_d   = fu_op2_q;
        fu_dst_d   = fu_dst_q;
        wi         = '0;
        if (flush) begin
            for (int r = 0; r < int'(NREG); r++) begin
                pos_d[r]  = '0;
                mask_d[r] = '0;
                lane_d[r] = '0;
            end
            fu_valid_d = '0;
            fu_op1_d   = '0;
            fu_op2_d   = '0;
            fu_dst_d   = '0;
        end else if (!stall) begin
            for (int r = 0; r < int'(NREG); r++) begin
                pos_d[r] = pos_q[r] >> 1;
                if (pos_d[r] == '0) begin
                    mask_d[r] = '0;
                    lane_d[r] = '0;
                end
            end
            // ascending lane order so the youngest writer of a register wins
            for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
                if (i < pop_len_c) begin
                    if (dst_need[i] && dst_addr[i*AW +: AW] != '0 &&
                        int'(dst_addr[i*AW +: AW]) < int'(NREG)) begin
                        wi         = RW'(dst_addr[i*AW +: AW]);
                        pos_d[wi]  = STAGES'(1) << (STAGES - 1);
                        mask_d[wi] = accept_mask[i*STAGES +: STAGES];
                        lane_d[wi] = LW'(i);
                    end
                    fu_valid_d[i]          = 1'b1;
                    fu_op1_d[i*DW +: DW]   = opnd_c[i][0];
                    fu_op2_d[i*DW +: DW]   = opnd_c[i][1];
                    fu_dst_d[i*6 +: 6]     = {dst_need[i], dst_addr[i*AW +: AW]};
                end else begin
                    fu_valid_d[i]          = 1'b0;
                    fu_op1_d[i*DW +: DW]   = '0;
                    fu_op2_d[i*DW +: DW]   = '0;
                    fu_dst_d[i*6 +: 6]     = '0;
                end
            end
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < int'(NREG); r++) begin
                pos_q[r]  <= '0;
                mask_q[r] <= '0;
                lane_q[r] <= '0;
            end
            fu_valid_q <= '0;
            fu_op1_q   <= '0;
            fu_op2_q   <= '0;
            fu_dst_q   <= '0;
        end else begin
            pos_q      <= pos_d;
            mask_q     <= mask_d;
            lane_q     <= lane_d;
            fu_valid_q <= fu_valid_d;
            fu_op1_q   <= fu_op1_d;
            fu_op2_q   <= fu_op2_d;
            fu_dst_q   <= fu_dst_d;
        end
    end

endmodule

// File: tb/tb_issue_ctrl_n.sv
// Self-checking bench for issue_ctrl_n (ISSUE_WIDTH=2, STAGES=3, NREG=32).
module tb_issue_ctrl_n;

    localparam int W = 2;
    localparam int S = 3;

    logic         clk, rst_n, flush, stall;
    logic [1:0]   iq_size;
    logic [3:0]   src_need;
    logic [19:0]  src_addr;
    logic [127:0] imm;
    logic [1:0]   dst_need;
    logic [9:0]   dst_addr;
    logic [5:0]   accept_mask;
    logic [1:0]   is_branch;
    logic [19:0]  rf_raddr;
    logic [127:0] rf_rdata;
    logic [191:0] byp_data;
    logic [1:0]   iq_pop;
    logic [1:0]   fu_valid;
    logic [63:0]  fu_op1, fu_op2;
    logic [11:0]  fu_dst;

    issue_ctrl_n #(.ISSUE_WIDTH(W), .STAGES(S), .NREG(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .stall(stall),
        .iq_size(iq_size), .src_need(src_need), .src_addr(src_addr), .imm(imm),
        .dst_need(dst_need), .dst_addr(dst_addr), .accept_mask(accept_mask),
        .is_branch(is_branch), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
        .byp_data(byp_data), .iq_pop(iq_pop), .fu_valid(fu_valid),
        .fu_op1(fu_op1), .fu_op2(fu_op2), .fu_dst(fu_dst)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: per register, cycles left until writeback (0 = nothing in flight).
    int         age   [32];
    logic [2:0] mmask [32];
    int         mlane [32];
    int         m_pop;
    logic [31:0] m_op [W][2];
    logic [1:0]  e_valid;
    logic [63:0] e_op1, e_op2;
    logic [11:0] e_dst;

    typedef struct {
        logic [1:0] size;
        logic [3:0] sn;
        logic [4:0] a0, a1, a2, a3;
        logic [1:0] dn;
        logic [4:0] d0, d1;
        logic [2:0] m0, m1;
        logic [1:0] br;
        logic       st, fl;
        int         pop;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic [1:0] size, logic [3:0] sn, logic [4:0] a0, logic [4:0] a1,
                               logic [4:0] a2, logic [4:0] a3, logic [1:0] dn, logic [4:0] d0,
                               logic [4:0] d1, logic [2:0] m0, logic [2:0] m1, logic [1:0] br,
                               logic st, logic fl, int pop);
        vec_t r;
        r.size = size; r.sn = sn; r.a0 = a0; r.a1 = a1; r.a2 = a2; r.a3 = a3;
        r.dn = dn; r.d0 = d0; r.d1 = d1; r.m0 = m0; r.m1 = m1; r.br = br;
        r.st = st; r.fl = fl; r.pop = pop;
        return r;
    endfunction

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int r = 0; r < 32; r++) begin
            age[r] = 0; mmask[r] = '0; mlane[r] = 0;
        end
        e_valid = '0; e_op1 = '0; e_op2 = '0; e_dst = '0;
    endtask

    // Spec-level evaluation of the current group against the model.
    task automatic model_eval();
        int  p;
        bit  stop;
        bit  ok;
        int  k;
        int  a;
        p = 0; stop = 0;
        for (int i = 0; i < W; i++) begin
            ok = (i < int'(iq_size));
            for (int s = 0; s < 2; s++) begin
                k = 2 * i + s;
                a = int'(src_addr[k*5 +: 5]);
                if (!src_need[k]) begin
                    m_op[i][s] = imm[k*32 +: 32];
                end else begin
                    m_op[i][s] = rf_rdata[k*32 +: 32];
                    if (a != 0 && age[a] > 0) begin
                        if (mmask[a][age[a]-1])
                            m_op[i][s] = byp_data[((age[a]-1)*W + mlane[a])*32 +: 32];
                        else
                            ok = 0;
                    end
                    for (int j = 0; j < i; j++)
                        if (dst_need[j] && dst_addr[j*5 +: 5] != 5'd0 && int'(dst_addr[j*5 +: 5]) == a)
                            ok = 0;
                end
            end
            if (!stop && ok) p = i + 1; else stop = 1;
        end
        while (p > 0 && is_branch[p-1]) p--;
        if (stall || flush) p = 0;
        m_pop = p;
    endtask

    task automatic model_commit();
        int d;
        if (flush) begin
            model_reset();
        end else if (!stall) begin
            for (int r = 0; r < 32; r++) begin
                if (age[r] > 0) age[r]--;
                if (age[r] == 0) begin mmask[r] = '0; mlane[r] = 0; end
            end
            for (int i = 0; i < W; i++) begin
                if (i < m_pop) begin
                    d = int'(dst_addr[i*5 +: 5]);
                    if (dst_need[i] && d != 0) begin
                        age[d] = S; mmask[d] = accept_mask[i*3 +: 3]; mlane[d] = i;
                    end
                    e_valid[i] = 1'b1;
                    e_op1[i*32 +: 32] = m_op[i][0];
                    e_op2[i*32 +: 32] = m_op[i][1];
                    e_dst[i*6 +: 6] = {dst_need[i], dst_addr[i*5 +: 5]};
                end else begin
                    e_valid[i] = 1'b0;
                    e_op1[i*32 +: 32] = '0;
                    e_op2[i*32 +: 32] = '0;
                    e_dst[i*6 +: 6] = '0;
                end
            end
        end
    endtask

    // One cycle: inputs already driven (posedge+1); check comb, clock, check launch.
    task automatic step(string tag);
        #1;
        model_eval();
        check({tag, " iq_pop"}, 64'(iq_pop), 64'(m_pop));
        check({tag, " rf_raddr"}, 64'(rf_raddr), 64'(src_addr));
        @(posedge clk);
        #1;
        model_commit();
        check({tag, " fu_valid"}, 64'(fu_valid), 64'(e_valid));
        check({tag, " fu_op1"}, fu_op1, e_op1);
        check({tag, " fu_op2"}, fu_op2, e_op2);
        check({tag, " fu_dst"}, 64'(fu_dst), 64'(e_dst));
    endtask

    task automatic rand_data();
        imm      = {$urandom, $urandom, $urandom, $urandom};
        byp_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic apply_vec(vec_t t);
        iq_size = t.size; src_need = t.sn; src_addr = {t.a3, t.a2, t.a1, t.a0};
        dst_need = t.dn; dst_addr = {t.d1, t.d0}; accept_mask = {t.m1, t.m0};
        is_branch = t.br; stall = t.st; flush = t.fl;
        rf_rdata = {32'(t.a3), 32'(t.a2), 32'(t.a1), 32'(t.a0)};
        rand_data();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; flush = 1'b0; stall = 1'b0; iq_size = '0; src_need = '0;
        src_addr = '0; imm = '0; dst_need = '0; dst_addr = '0; accept_mask = '0;
        is_branch = '0; rf_rdata = '0; byp_data = '0;
        model_reset();

        #2;
        check("reset fu_valid", 64'(fu_valid), 64'd0);
        check("reset fu_op1", fu_op1, 64'd0);
        check("reset fu_op2", fu_op2, 64'd0);
        check("reset fu_dst", 64'(fu_dst), 64'd0);
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;

        //           size sn       a0 a1 a2 a3 dn     d0 d1 m0      m1      br     st fl pop
        tbl.push_back(v(2, 4'b1111, 1, 2, 3, 4, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 2));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 0, 2'b01, 5, 0, 3'b001, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(2, 4'b0100, 0, 0, 5, 0, 2'b01, 5, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 5, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(2, 4'b0000, 0, 0, 0, 0, 2'b01, 6, 0, 3'b000, 3'b000, 2'b10, 0, 0, 1));
        tbl.push_back(v(2, 4'b0100, 0, 0, 6, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b01, 0, 0, 0));
        tbl.push_back(v(2, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b01, 0, 0, 2));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 0, 2'b01, 7, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(1, 4'b0001, 7, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 7, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 7, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 1, 0, 0));
        tbl.push_back(v(1, 4'b0001, 7, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 0, 2'b01, 8, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(1, 4'b0001, 8, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 1, 1, 0));
        tbl.push_back(v(1, 4'b0001, 8, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(2, 4'b0000, 0, 0, 0, 0, 2'b11, 9, 9, 3'b100, 3'b001, 2'b00, 0, 0, 2));
        tbl.push_back(v(1, 4'b0001, 9, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 9, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));
        tbl.push_back(v(1, 4'b0001, 9, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(1, 4'b0000, 0, 0, 0, 0, 2'b01, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(1, 4'b0001, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        tbl.push_back(v(2, 4'b0100, 0, 0, 0, 0, 2'b01, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 2));
        tbl.push_back(v(0, 4'b0000, 0, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 0));

        for (int n = 0; n < tbl.size(); n++) begin
            apply_vec(tbl[n]);
            #1;
            check($sformatf("vec%0d pop", n), 64'(iq_pop), 64'(tbl[n].pop));
            step($sformatf("vec%0d", n));
            if (n == 0) begin
                check("first group op1 lane0", 64'(fu_op1[31:0]), 64'd1);
                check("first group op1 lane1", 64'(fu_op1[63:32]), 64'd3);
            end
        end

        // Asynchronous reset in the middle of operation.
        apply_vec(v(1, 4'b0000, 0, 0, 0, 0, 2'b01, 10, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        step("pre-reset write");
        rst_n = 1'b0;
        #1;
        check("async reset fu_valid", 64'(fu_valid), 64'd0);
        check("async reset fu_dst", 64'(fu_dst), 64'd0);
        model_reset();
        @(posedge clk); #1;
        rst_n = 1'b1;
        apply_vec(v(1, 4'b0001, 10, 0, 0, 0, 2'b00, 0, 0, 3'b000, 3'b000, 2'b00, 0, 0, 1));
        #1;
        check("post-reset reader pop", 64'(iq_pop), 64'd1);
        step("post-reset reader");

        // Randomised traffic against the model.
        for (int c = 0; c < 400; c++) begin
            iq_size = 2'($urandom_range(0, 2));
            src_need = 4'($urandom);
            for (int k = 0; k < 4; k++) src_addr[k*5 +: 5] = 5'($urandom_range(0, 7));
            dst_need = 2'($urandom);
            for (int k = 0; k < 2; k++) dst_addr[k*5 +: 5] = 5'($urandom_range(0, 7));
            accept_mask = 6'($urandom);
            is_branch = {($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0)};
            stall = ($urandom_range(0, 7) == 0);
            flush = ($urandom_range(0, 15) == 0);
            rf_rdata = {$urandom, $urandom, $urandom, $urandom};
            rand_data();
            step($sformatf("rand%0d", c));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
